// File: rtl/sonic_vc_block_splitter_pkg.sv
// -----------------------------------------------------------------------------
// sonic_vc_pkg
//   Shared constants and types for the VC block splitter.
//   - Beat layout: [65:0] block0, [131:66] block1, [132] single flag.
//   - Block layout: [1:0] sync header, [65:2] payload.
//   - Splitter FSM state enum.
//   - Sync header codes and the /I/ control idle block.
// -----------------------------------------------------------------------------
package sonic_vc_pkg;

  localparam int BLOCK_WIDTH = 66;
  localparam int DATA_WIDTH  = 2 * BLOCK_WIDTH + 1;

  // Field offsets inside one FIFO beat
  localparam int BLK0_LSB   = 0;
  localparam int BLK1_LSB   = 66;
  localparam int SINGLE_BIT = 132;

  // 64b/66b sync header codes
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Control block, block type 0x1E, all-idle payload: 66'h7A
  localparam logic [BLOCK_WIDTH-1:0] IDLE_BLOCK = {56'h0, 8'h1E, SYNC_CTRL};

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,  // nothing held
    ST_HOLD_LO = 2'd1,  // block0 of the held beat pending
    ST_HOLD_HI = 2'd2   // block1 of the held beat pending
  } state_e;

  // Only 01 and 10 are legal sync headers
  function automatic logic sync_hdr_bad(input logic [1:0] sh);
    return (sh != SYNC_DATA) && (sh != SYNC_CTRL);
  endfunction

endpackage

// File: rtl/sonic_vc_block_splitter_if.sv
// -----------------------------------------------------------------------------
// sonic_vc_block_splitter_if
//   Bundles both handshakes of the block splitter.
//   Input side  (FIFO -> splitter):   in_valid, in_ready, in_data (beat)
//   Output side (splitter -> gearbox): out_valid, out_ready, out_data (block)
//
//   Handshake rule for both sides: a transfer happens on a rising clk edge
//   where valid && ready are both 1. A source holds valid and data stable
//   until the transfer; ready may depend combinationally on the other side
//   but never on its own side's valid.
//
//   Modports: slave  = the splitter
//             master = the environment (FIFO + gearbox)
// -----------------------------------------------------------------------------
interface sonic_vc_block_splitter_if
  import sonic_vc_pkg::*;
#(
  parameter int BLOCK_WIDTH = sonic_vc_pkg::BLOCK_WIDTH,
  parameter int DATA_WIDTH  = sonic_vc_pkg::DATA_WIDTH
);

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [BLOCK_WIDTH-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/sonic_vc_block_splitter_sat_counter.sv
// -----------------------------------------------------------------------------
// sonic_vc_sat_counter
//   Saturating event counter with synchronous clear.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : synchronous clear, wins over inc
//     inc        : count one event this cycle
//     cnt        : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module sonic_vc_sat_counter
  import sonic_vc_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sonic_vc_block_splitter.sv
// -----------------------------------------------------------------------------
// sonic_vc_block_splitter
//   Takes 133-bit FIFO beats (two 66-bit PCS blocks + single flag) and emits
//   one 66-bit block per transfer toward the PCS TX gearbox. block0 always
//   goes first; block1 is skipped when the single flag is set. The flag
//   itself is never forwarded. Sync-header errors and underflow cycles are
//   counted in saturating counters.
//
//   Ports:
//     clk, reset_n   : clock, asynchronous active-low reset
//     bus (slave)    : in_valid/in_ready/in_data, out_valid/out_ready/out_data
//     stats_clr      : synchronous clear of both counters (beats increments)
//     hdr_err_cnt    : forwarded blocks whose sync header was 00 or 11
//     underflow_cnt  : cycles with out_ready=1 while nothing is held
//     state_dbg      : current FSM state
//
//   Build option SONIC_VC_IDLE_INSERT_EN: when defined, the EMPTY state
//   presents a valid /I/ idle block instead of out_valid=0.
// -----------------------------------------------------------------------------
module sonic_vc_block_splitter
  import sonic_vc_pkg::*;
#(
  parameter int BLOCK_WIDTH = sonic_vc_pkg::BLOCK_WIDTH,
  parameter int DATA_WIDTH  = sonic_vc_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  sonic_vc_block_splitter_if.slave      bus,
  input  logic                          stats_clr,
  output logic [CNT_WIDTH-1:0]          hdr_err_cnt,
  output logic [CNT_WIDTH-1:0]          underflow_cnt,
  output state_e                        state_dbg
);

  state_e                 state_q;
  state_e                 state_d;
  logic [DATA_WIDTH-1:0]  hold_q;
  logic [DATA_WIDTH-1:0]  hold_d;

  logic                   in_ready;
  logic                   out_valid;
  logic [BLOCK_WIDTH-1:0] out_data;
  logic                   in_fire;
  logic                   out_fire;
  logic                   hold_single;
  logic                   hdr_err_inc;
  logic                   underflow_inc;

  assign hold_single = hold_q[SINGLE_BIT];

  // Output/ready decode followed by next-state. in_ready only rises in a
  // HOLD state when the block leaving this cycle is the last one of the
  // held beat, which is what allows a new beat every block with no bubble.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;

    case (state_q)
      ST_EMPTY: begin
        in_ready = 1'b1;
`ifdef SONIC_VC_IDLE_INSERT_EN
        out_valid = 1'b1;
        out_data  = IDLE_BLOCK;
`else
        out_valid = 1'b0;
        out_data  = '0;
`endif
      end
      ST_HOLD_LO: begin
        out_valid = 1'b1;
        out_data  = hold_q[BLK0_LSB +: BLOCK_WIDTH];
        in_ready  = bus.out_ready && hold_single;
      end
      ST_HOLD_HI: begin
        out_valid = 1'b1;
        out_data  = hold_q[BLK1_LSB +: BLOCK_WIDTH];
        in_ready  = bus.out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase

    in_fire  = bus.in_valid && in_ready;
    out_fire = out_valid && bus.out_ready;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          hold_d  = bus.in_data;
          state_d = ST_HOLD_LO;
        end
      end
      ST_HOLD_LO: begin
        if (out_fire) begin
          if (!hold_single) begin
            state_d = ST_HOLD_HI;
          end else if (in_fire) begin
            hold_d  = bus.in_data;
            state_d = ST_HOLD_LO;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      ST_HOLD_HI: begin
        if (out_fire) begin
          if (in_fire) begin
            hold_d  = bus.in_data;
            state_d = ST_HOLD_LO;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Idle blocks from EMPTY are filler, not traffic: only held blocks are
  // checked for bad sync headers.
  assign hdr_err_inc   = out_fire && (state_q != ST_EMPTY) && sync_hdr_bad(out_data[1:0]);
  assign underflow_inc = bus.out_ready && (state_q == ST_EMPTY);

  sonic_vc_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_hdr_err_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (stats_clr),
    .inc   (hdr_err_inc),
    .cnt   (hdr_err_cnt)
  );

  sonic_vc_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_underflow_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (stats_clr),
    .inc   (underflow_inc),
    .cnt   (underflow_cnt)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign state_dbg     = state_q;

endmodule
